// File: rtl/hex_bus_pkg.sv
// Shared types, key indices, status layout and the round-robin pick for hex_bus_arbiter.
// Pure declarations; the pick function is combinational.
package hex_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FROZEN = 2'd2
    } arb_state_e;

    localparam int KEY_FREEZE = 0;
    localparam int KEY_SKIP   = 1;
    localparam int KEY_CLEAR  = 2;

    localparam int STAT_HOLD_BIT   = 0;
    localparam int STAT_FROZEN_BIT = 1;
    localparam int STAT_LAST_LSB   = 8;
    localparam int STAT_CNT_LSB    = 16;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First asserted request searching last+1, last+2, ... modulo num (num <= 8).
    function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int unsigned num);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            cand = (32'(last) + k) % num;
            if (k <= num && !r.found && req[cand[2:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_bus_arbiter_if.sv
// Requester-side request/grant bundle for hex_bus_arbiter.
// Requesters hold req until a one-cycle gnt pulse; data sampled only at grant.
interface hex_bus_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;

    modport master (output req, output req_data, input gnt);
    modport slave  (input req, input req_data, output gnt);
endinterface

// File: rtl/hex_bus_arbiter_button_debounce.sv
// Active-low key synchronizer + debouncer producing a one-cycle press pulse on release->press.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable samples; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level flips; a pulse only when leaving the released (high) level.
                level <= sync2;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/hex_bus_arbiter.sv
// Round-robin owner of the HEX5..HEX0 word with minimum hold, freeze/skip/clear keys and status.
// Grant and hex_bus register one edge after req is sampled; losers simply keep req high.
module hex_bus_arbiter
    import hex_bus_pkg::*;
#(
    parameter int          NUM_REQ         = 3,
    parameter int          HOLD_CYCLES     = 50_000_000,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [31:0] BLANK_VALUE     = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    hex_bus_arbiter_if.slave    req_if,
    input  logic [2:0]          pushbuttons,
    output logic [31:0]         hex_bus,
    output logic [31:0]         status_readdata
);
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [2:0] press;

    for (genvar k = 0; k < 3; k++) begin : g_key
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .key_n (pushbuttons[k]),
            .press (press[k])
        );
    end

    arb_state_e         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [2:0]         last_q, last_d;
    logic [15:0]        gcnt_q, gcnt_d;
    logic [31:0]        hex_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [31:0]        status_d;
    rr_pick_t           pick;

    assign pick = rr_pick(8'(req_if.req), last_q, NUM_REQ);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        gcnt_d  = gcnt_q;
        hex_d   = hex_bus;
        gnt_d   = '0;

        if (press[KEY_FREEZE]) begin
            // Freeze wins over skip; a simultaneous clear still blanks the bus.
            state_d = (state_q == FROZEN) ? IDLE : FROZEN;
            hold_d  = '0;
            if (press[KEY_CLEAR]) hex_d = BLANK_VALUE;
        end else if (press[KEY_CLEAR]) begin
            hex_d = BLANK_VALUE;
            if (state_q == HOLD) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick.found) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                        last_d  = pick.idx;
                        if (gcnt_q != 16'hFFFF) gcnt_d = gcnt_q + 16'd1;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            gnt_d[i] = (3'(i) == pick.idx);
                            if (3'(i) == pick.idx) hex_d = req_if.req_data[32*i +: 32];
                        end
                    end
                end
                HOLD: begin
                    if (press[KEY_SKIP] || hold_q == '0) state_d = IDLE;
                    else                                  hold_d  = hold_q - HW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        status_d                         = '0;
        status_d[STAT_CNT_LSB +: 16]     = gcnt_d;
        status_d[STAT_LAST_LSB +: 8]     = 8'(last_d);
        status_d[STAT_FROZEN_BIT]        = (state_d == FROZEN);
        status_d[STAT_HOLD_BIT]          = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            last_q          <= 3'(NUM_REQ - 1);
            gcnt_q          <= '0;
            hex_bus         <= BLANK_VALUE;
            req_if.gnt      <= '0;
            status_readdata <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            last_q          <= last_d;
            gcnt_q          <= gcnt_d;
            hex_bus         <= hex_d;
            req_if.gnt      <= gnt_d;
            status_readdata <= status_d;
        end
    end
endmodule

// File: tb/tb_hex_bus_arbiter.sv
// Randomized and directed bench for hex_bus_arbiter against a cycle-level behavioural model.
module tb_hex_bus_arbiter;
    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pushbuttons;
    logic [31:0] hex_bus;
    logic [31:0] status_readdata;

    hex_bus_arbiter_if #(.NUM_REQ(N)) bus ();

    hex_bus_arbiter #(
        .NUM_REQ(N), .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(DEB), .BLANK_VALUE(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .req_if(bus), .pushbuttons(pushbuttons),
        .hex_bus(hex_bus), .status_readdata(status_readdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             edge_no = 0;
    logic [DEB-1:0] m_hist [3];
    logic           m_s1 [3], m_s2 [3], m_lvl [3], m_prs [3];
    bit             m_frozen, m_in_hold;
    int             m_hold_end, m_last, m_cnt;
    logic [31:0]    m_hex, m_status;
    logic [N-1:0]   m_gnt;

    function automatic int winner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        edge_no++;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = '1; m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_lvl[b] = 1'b1; m_prs[b] = 1'b0;
            end
            m_frozen = 1'b0; m_in_hold = 1'b0; m_hold_end = 0; m_last = N - 1; m_cnt = 0;
            m_hex = 32'h0; m_gnt = '0; m_status = 32'h0;
            return;
        end
        m_gnt = '0;
        if (m_prs[0]) begin
            m_frozen  = !m_frozen;
            m_in_hold = 1'b0;
            if (m_prs[2]) m_hex = 32'h0;
        end else if (m_prs[2]) begin
            m_hex     = 32'h0;
            m_in_hold = 1'b0;
        end else if (m_frozen) begin
        end else if (m_in_hold) begin
            if (m_prs[1] || edge_no >= m_hold_end) m_in_hold = 1'b0;
        end else begin
            w = winner(bus.req, m_last);
            if (w >= 0) begin
                m_hex      = bus.req_data[32*w +: 32];
                m_gnt      = N'(1) << w;
                m_last     = w;
                if (m_cnt < 65535) m_cnt++;
                m_in_hold  = 1'b1;
                m_hold_end = edge_no + HOLD;
            end
        end
        m_status = {16'(m_cnt), 8'(m_last), 6'b0, m_frozen, m_in_hold};
        // Key level flips once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            m_prs[b]  = 1'b0;
            m_hist[b] = {m_hist[b][DEB-2:0], m_s2[b]};
            if (m_hist[b] == {DEB{~m_lvl[b]}}) begin
                m_prs[b] = m_lvl[b];
                m_lvl[b] = ~m_lvl[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = pushbuttons[b];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("gnt", 32'(bus.gnt), 32'(m_gnt));
            chk("hex_bus", hex_bus, m_hex);
            chk("status", status_readdata, m_status);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input string name, input int maxc, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.gnt == '0 && waited < maxc);
        chk({name, "_seen"}, 32'(bus.gnt != '0), 32'd1);
    endtask

    task automatic press_key(input int b, input int len);
        pushbuttons[b] = 1'b0;
        repeat (len) @(negedge clk);
        pushbuttons[b] = 1'b1;
    endtask

    logic [31:0] wd [3];
    int          waited;
    int          key_left [3];

    initial begin
        wd = '{32'h11111111, 32'h22222222, 32'h33333333};
        reset = 1'b1; pushbuttons = 3'b111; bus.req = '0; bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_hex", hex_bus, 32'h0);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_status", status_readdata, 32'h0);

        // All three requesting: 0,1,2,0 spaced by one grant cycle plus HOLD.
        reset = 1'b0;
        bus.req_data = {wd[2], wd[1], wd[0]};
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr", 20, waited);
            chk("rr_spacing", 32'(waited), (k == 0) ? 32'd1 : 32'd9);
            chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 3)));
            chk("rr_hex", hex_bus, wd[k % 3]);
            chk("rr_count", 32'(status_readdata[31:16]), 32'(k + 1));
        end
        bus.req = '0;
        repeat (12) @(negedge clk);

        // Lone requester 2, then freeze during its hold.
        bus.req_data[95:64] = 32'hABCD0123;
        bus.req = 3'b100;
        wait_gnt("solo", 5, waited);
        chk("solo_lat", 32'(waited), 32'd1);
        chk("solo_gnt", 32'(bus.gnt), 32'h4);
        chk("solo_hex", hex_bus, 32'hABCD0123);
        bus.req = 3'b011;
        pushbuttons[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("hold_gnt", 32'(bus.gnt), 32'h0);
            chk("hold_bit", 32'(status_readdata[0]), 32'd1);
            chk("hold_last", 32'(status_readdata[15:8]), 32'd2);
        end
        @(negedge clk);
        pushbuttons[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("frozen_gnt", 32'(bus.gnt), 32'h0);
        end
        chk("frozen_bit", 32'(status_readdata[1]), 32'd1);
        press_key(0, 6);
        wait_gnt("unfreeze", 20, waited);
        chk("unfreeze_gnt", 32'(bus.gnt), 32'h1);
        chk("unfreeze_bit", 32'(status_readdata[1]), 32'd0);
        bus.req = '0;
        repeat (20) @(negedge clk);

        // Two-cycle glitch on KEY0 must not freeze.
        press_key(0, 2);
        repeat (15) @(negedge clk);
        chk("glitch_frozen", 32'(status_readdata[1]), 32'd0);

        // Clear lands on the same edge a winner appears.
        press_key(2, 6);
        bus.req = 3'b010;
        @(negedge clk);
        chk("clear_hex", hex_bus, 32'h0);
        chk("clear_gnt", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        chk("after_clear_gnt", 32'(bus.gnt), 32'h2);
        chk("after_clear_hex", hex_bus, 32'h22222222);
        bus.req = '0;
        repeat (20) @(negedge clk);

        // Skip press arrives two edges into a hold with requester 1 pending.
        pushbuttons[1] = 1'b0;
        repeat (4) @(negedge clk);
        bus.req = 3'b001;
        @(negedge clk);
        chk("skip_first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 3'b010;
        @(negedge clk);
        pushbuttons[1] = 1'b1;
        chk("skip_in_hold", 32'(status_readdata[0]), 32'd1);
        @(negedge clk);
        chk("skip_idle", 32'(status_readdata[0]), 32'd0);
        @(negedge clk);
        chk("skip_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        repeat (10) @(negedge clk);

        // Random traffic, key activity and occasional resets.
        for (int b = 0; b < 3; b++) key_left[b] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && bus.gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 63) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req_data[32*i +: 32] = $urandom;
                    bus.req[i] = 1'b1;
                end
            end
            for (int b = 0; b < 3; b++) begin
                if (key_left[b] > 0) begin
                    key_left[b]--;
                    if (key_left[b] == 0) pushbuttons[b] = 1'b1;
                end else if ($urandom_range(0, 79) == 0) begin
                    pushbuttons[b] = 1'b0;
                    key_left[b]    = $urandom_range(1, 8);
                end
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
